rbt_s_hdr_arbiter: RTL and testbench

Round-robin arbiter that shares one proto-header stream (length, PHV, header data) between `PORTS` upstream requesters, typically per-port parser front ends, and feeds the single `rbt_s_post_parser` instance downstream. It has one registered output stage. It can stamp the winning port index into the PHV in-port byte. It keeps per-port accept counters for debug.

---
 rtl/rbt_s_hdr_arbiter_if.sv | 41 ++++
 rtl/rbt_s_hdr_arbiter.sv | 132 +++++++++++++
 tb/tb_rbt_s_hdr_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rbt_s_hdr_arbiter_if.sv
// Proto-header bus shared between PORTS upstream requesters, the arbiter
// and the downstream post-parser. The master modport is the environment
// view: it drives requests and downstream ready. The slave modport is the
// arbiter view.
//   in_proto_hdr_*   : per-port valid/ready/length/PHV/data, port i at [i*W +: W]
//   out_proto_hdr_*  : single registered output stream
//   out_grant_port   : source port of the beat held in the output register
//   accept_cnt       : per-port accepted-beat counters, port i at [i*CNT_WIDTH +: CNT_WIDTH]
interface rbt_s_hdr_arbiter_if #(
  parameter int unsigned PORTS        = 2,
  parameter int unsigned HEADER_WIDTH = 2048,
  parameter int unsigned PHV_WIDTH    = 408,
  parameter int unsigned CNT_WIDTH    = 32
);
  logic [PORTS-1:0]              in_proto_hdr_valid;
  logic [PORTS-1:0]              in_proto_hdr_ready;
  logic [PORTS*16-1:0]           in_proto_hdr_length;
  logic [PORTS*PHV_WIDTH-1:0]    in_proto_hdr_phv;
  logic [PORTS*HEADER_WIDTH-1:0] in_proto_hdr_data;
  logic                          out_proto_hdr_valid;
  logic                          out_proto_hdr_ready;
  logic [15:0]                   out_proto_hdr_length;
  logic [PHV_WIDTH-1:0]          out_proto_hdr_phv;
  logic [HEADER_WIDTH-1:0]       out_proto_hdr_data;
  logic [2:0]                    out_grant_port;
  logic [PORTS*CNT_WIDTH-1:0]    accept_cnt;

  modport master (
    output in_proto_hdr_valid, in_proto_hdr_length, in_proto_hdr_phv,
           in_proto_hdr_data, out_proto_hdr_ready,
    input  in_proto_hdr_ready, out_proto_hdr_valid, out_proto_hdr_length,
           out_proto_hdr_phv, out_proto_hdr_data, out_grant_port, accept_cnt
  );

  modport slave (
    input  in_proto_hdr_valid, in_proto_hdr_length, in_proto_hdr_phv,
           in_proto_hdr_data, out_proto_hdr_ready,
    output in_proto_hdr_ready, out_proto_hdr_valid, out_proto_hdr_length,
           out_proto_hdr_phv, out_proto_hdr_data, out_grant_port, accept_cnt
  );
endinterface

// File: rtl/rbt_s_hdr_arbiter.sv
// Round-robin arbiter merging PORTS proto-header streams into one registered
// output stream for the post-parser. Optionally stamps the granted port index
// into PHV byte INPORT_BYTE and keeps per-port accept counters.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : rbt_s_hdr_arbiter_if slave view (all request/output/debug signals)
module rbt_s_hdr_arbiter #(
  parameter int unsigned PORTS        = 2,
  parameter int unsigned HEADER_WIDTH = 2048,
  parameter int unsigned PHV_WIDTH    = 408,
  parameter int unsigned INPORT_BYTE  = 2,
  parameter int unsigned STAMP_INPORT = 1,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input logic                clk,
  input logic                rst_n,
  rbt_s_hdr_arbiter_if.slave bus
);

  logic [2:0]              last_grant;
  logic [2:0]              gnt;
  logic [2:0]              gnt_hi;
  logic [2:0]              gnt_lo;
  logic                    hi_ok;
  logic                    lo_ok;
  logic                    gnt_valid;
  logic                    slot_free;
  logic                    take;
  logic [PORTS-1:0]        ready;
  logic [15:0]             sel_len;
  logic [PHV_WIDTH-1:0]    sel_phv;
  logic [HEADER_WIDTH-1:0] sel_data;

  logic                    out_valid;
  logic [15:0]             out_len;
  logic [PHV_WIDTH-1:0]    out_phv;
  logic [HEADER_WIDTH-1:0] out_data;
  logic [2:0]              out_port;
  logic [CNT_WIDTH-1:0]    cnt [PORTS];

  // Rotating priority: the lowest valid port above last_grant wins; if none,
  // wrap around to the lowest valid port at or below last_grant.
  always_comb begin
    gnt_hi = '0;
    gnt_lo = '0;
    hi_ok  = 1'b0;
    lo_ok  = 1'b0;
    for (int unsigned p = 0; p < PORTS; p++) begin
      if (bus.in_proto_hdr_valid[p]) begin
        if (3'(p) > last_grant) begin
          if (!hi_ok) begin
            gnt_hi = 3'(p);
            hi_ok  = 1'b1;
          end
        end else if (!lo_ok) begin
          gnt_lo = 3'(p);
          lo_ok  = 1'b1;
        end
      end
    end
    gnt       = hi_ok ? gnt_hi : gnt_lo;
    gnt_valid = hi_ok | lo_ok;
  end

  assign slot_free = !out_valid || bus.out_proto_hdr_ready;
  // rst_n gating keeps every ready low while reset is held.
  assign take      = rst_n && slot_free && gnt_valid;

  always_comb begin
    ready    = '0;
    sel_len  = '0;
    sel_phv  = '0;
    sel_data = '0;
    for (int unsigned p = 0; p < PORTS; p++) begin
      ready[p] = take && (gnt == 3'(p));
      if (gnt == 3'(p)) begin
        sel_len  = bus.in_proto_hdr_length[p*16 +: 16];
        sel_phv  = bus.in_proto_hdr_phv[p*PHV_WIDTH +: PHV_WIDTH];
        sel_data = bus.in_proto_hdr_data[p*HEADER_WIDTH +: HEADER_WIDTH];
      end
    end
    if (STAMP_INPORT != 0) begin
      sel_phv[INPORT_BYTE*8 +: 8] = {5'b0, gnt};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_len    <= '0;
      out_phv    <= '0;
      out_data   <= '0;
      out_port   <= '0;
      last_grant <= 3'(PORTS - 1);
      for (int unsigned p = 0; p < PORTS; p++) begin
        cnt[p] <= '0;
      end
    end else begin
      if (take) begin
        out_valid  <= 1'b1;
        out_len    <= sel_len;
        out_phv    <= sel_phv;
        out_data   <= sel_data;
        out_port   <= gnt;
        last_grant <= gnt;
      end else if (bus.out_proto_hdr_ready) begin
        out_valid <= 1'b0;
      end
      for (int unsigned p = 0; p < PORTS; p++) begin
        if (take && (gnt == 3'(p))) begin
          cnt[p] <= cnt[p] + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    bus.accept_cnt = '0;
    for (int unsigned p = 0; p < PORTS; p++) begin
      bus.accept_cnt[p*CNT_WIDTH +: CNT_WIDTH] = cnt[p];
    end
  end

  assign bus.in_proto_hdr_ready   = ready;
  assign bus.out_proto_hdr_valid  = out_valid;
  assign bus.out_proto_hdr_length = out_len;
  assign bus.out_proto_hdr_phv    = out_phv;
  assign bus.out_proto_hdr_data   = out_data;
  assign bus.out_grant_port       = out_port;

endmodule

// File: tb/tb_rbt_s_hdr_arbiter.sv
// Bench for rbt_s_hdr_arbiter. Instance a: PORTS=2, stamping on, default
// widths. Instance b: PORTS=3, stamping off, narrow widths, 8-bit counters.
// A reference model per instance is compared on every falling edge; directed
// steps add hand-computed literal expectations.
module tb_rbt_s_hdr_arbiter;

  logic clk;
  logic rst_a;
  logic rst_b;

  rbt_s_hdr_arbiter_if #(.PORTS(2)) bus_a ();
  rbt_s_hdr_arbiter_if #(.PORTS(3), .HEADER_WIDTH(64), .PHV_WIDTH(32), .CNT_WIDTH(8)) bus_b ();

  rbt_s_hdr_arbiter #(.PORTS(2), .STAMP_INPORT(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_a),
    .bus   (bus_a.slave)
  );

  rbt_s_hdr_arbiter #(.PORTS(3), .HEADER_WIDTH(64), .PHV_WIDTH(32), .STAMP_INPORT(0),
                      .CNT_WIDTH(8)) dut_b (
    .clk   (clk),
    .rst_n (rst_b),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic chk_w(input string name, input logic [2047:0] got, input logic [2047:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got low64 %0h, expected low64 %0h (t=%0t)", name,
                  got[63:0], exp[63:0], $time);
  endtask

  // ---------------- reference model ----------------
  int              m_np    [2];
  bit              m_stamp [2];
  int              m_cw    [2];
  bit              m_valid [2];
  logic [15:0]     m_len   [2];
  logic [407:0]    m_phv   [2];
  logic [2047:0]   m_data  [2];
  int              m_port  [2];
  int              m_last  [2];
  longint unsigned m_cnt   [2][3];

  logic            s_rst   [2];
  logic            s_ordy  [2];
  logic [2:0]      s_v     [2];
  logic [15:0]     s_len   [2][3];
  logic [407:0]    s_phv   [2][3];
  logic [2047:0]   s_data  [2][3];

  logic [2:0]      d_rdy   [2];
  logic            d_valid [2];
  logic [15:0]     d_len   [2];
  logic [407:0]    d_phv   [2];
  logic [2047:0]   d_data  [2];
  logic [2:0]      d_port  [2];
  longint unsigned d_cnt   [2][3];

  // First valid port after 'last' going upward with wrap, or -1.
  function automatic int rr_pick(input logic [2:0] v, input int last, input int n);
    for (int s = 1; s <= n; s++) begin
      int p;
      p = (last + s) % n;
      if (v[p]) return p;
    end
    return -1;
  endfunction

  task automatic model_reset(input int k);
    m_valid[k] = 1'b0;
    m_len[k]   = '0;
    m_phv[k]   = '0;
    m_data[k]  = '0;
    m_port[k]  = 0;
    m_last[k]  = m_np[k] - 1;
    for (int p = 0; p < 3; p++) m_cnt[k][p] = 0;
  endtask

  task automatic snap_in();
    s_rst[0]  = rst_a;
    s_rst[1]  = rst_b;
    s_ordy[0] = bus_a.out_proto_hdr_ready;
    s_ordy[1] = bus_b.out_proto_hdr_ready;
    s_v[0]    = {1'b0, bus_a.in_proto_hdr_valid};
    s_v[1]    = bus_b.in_proto_hdr_valid;
    s_len[0][2] = '0;
    s_phv[0][2] = '0;
    s_data[0][2] = '0;
    for (int p = 0; p < 2; p++) begin
      s_len[0][p]  = bus_a.in_proto_hdr_length[p*16 +: 16];
      s_phv[0][p]  = bus_a.in_proto_hdr_phv[p*408 +: 408];
      s_data[0][p] = bus_a.in_proto_hdr_data[p*2048 +: 2048];
    end
    for (int p = 0; p < 3; p++) begin
      s_len[1][p]  = bus_b.in_proto_hdr_length[p*16 +: 16];
      s_phv[1][p]  = 408'(bus_b.in_proto_hdr_phv[p*32 +: 32]);
      s_data[1][p] = 2048'(bus_b.in_proto_hdr_data[p*64 +: 64]);
    end
  endtask

  task automatic snap_dut();
    d_rdy[0]   = {1'b0, bus_a.in_proto_hdr_ready};
    d_rdy[1]   = bus_b.in_proto_hdr_ready;
    d_valid[0] = bus_a.out_proto_hdr_valid;
    d_valid[1] = bus_b.out_proto_hdr_valid;
    d_len[0]   = bus_a.out_proto_hdr_length;
    d_len[1]   = bus_b.out_proto_hdr_length;
    d_phv[0]   = bus_a.out_proto_hdr_phv;
    d_phv[1]   = 408'(bus_b.out_proto_hdr_phv);
    d_data[0]  = bus_a.out_proto_hdr_data;
    d_data[1]  = 2048'(bus_b.out_proto_hdr_data);
    d_port[0]  = bus_a.out_grant_port;
    d_port[1]  = bus_b.out_grant_port;
    d_cnt[0][2] = 0;
    for (int p = 0; p < 2; p++) d_cnt[0][p] = 64'(bus_a.accept_cnt[p*32 +: 32]);
    for (int p = 0; p < 3; p++) d_cnt[1][p] = 64'(bus_b.accept_cnt[p*8 +: 8]);
  endtask

  task automatic model_step(input int k);
    int g;
    bit free;
    free = !m_valid[k] || s_ordy[k];
    g = rr_pick(s_v[k], m_last[k], m_np[k]);
    if (free && g >= 0) begin
      m_valid[k] = 1'b1;
      m_len[k]   = s_len[k][g];
      m_phv[k]   = s_phv[k][g];
      if (m_stamp[k]) m_phv[k][16 +: 8] = 8'(g);
      m_data[k]  = s_data[k][g];
      m_port[k]  = g;
      m_last[k]  = g;
      m_cnt[k][g] = (m_cnt[k][g] + 1) & ((64'd1 << m_cw[k]) - 1);
    end else if (s_ordy[k]) begin
      m_valid[k] = 1'b0;
    end
  endtask

  task automatic cmp(input int k);
    string t;
    logic [2:0] er;
    int g;
    t  = (k == 0) ? "a" : "b";
    er = '0;
    g  = rr_pick(s_v[k], m_last[k], m_np[k]);
    if (s_rst[k] && (!m_valid[k] || s_ordy[k]) && g >= 0) er[g] = 1'b1;
    chk({t, "_ready"}, 64'(d_rdy[k]), 64'(er));
    chk({t, "_out_valid"}, 64'(d_valid[k]), 64'(m_valid[k]));
    chk({t, "_out_len"}, 64'(d_len[k]), 64'(m_len[k]));
    chk({t, "_out_port"}, 64'(d_port[k]), 64'(m_port[k]));
    chk_w({t, "_out_phv"}, 2048'(d_phv[k]), 2048'(m_phv[k]));
    chk_w({t, "_out_data"}, d_data[k], m_data[k]);
    for (int p = 0; p < m_np[k]; p++)
      chk($sformatf("%s_cnt%0d", t, p), d_cnt[k][p], m_cnt[k][p]);
  endtask

  always @(posedge clk) begin
    snap_in();
    for (int k = 0; k < 2; k++) begin
      if (!s_rst[k]) model_reset(k);
      else model_step(k);
    end
  end

  always @(negedge rst_a) model_reset(0);
  always @(negedge rst_b) model_reset(1);

  always @(negedge clk) begin
    snap_in();
    snap_dut();
    cmp(0);
    cmp(1);
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [2047:0] mk_data(input logic [15:0] len, input int p);
    return {32{{8'(p), 40'hDA7A5EED00, len}}};
  endfunction

  function automatic logic [407:0] mk_phv(input logic [15:0] len);
    return {51{len[7:0]}};
  endfunction

  task automatic a_set(input int p, input logic v, input logic [15:0] len, input logic [407:0] phv);
    bus_a.in_proto_hdr_valid[p] = v;
    bus_a.in_proto_hdr_length[p*16 +: 16] = len;
    bus_a.in_proto_hdr_phv[p*408 +: 408] = phv;
    bus_a.in_proto_hdr_data[p*2048 +: 2048] = mk_data(len, p);
  endtask

  task automatic b_set(input int p, input logic v, input logic [15:0] len, input logic [31:0] phv);
    logic [2047:0] d;
    d = mk_data(len, p);
    bus_b.in_proto_hdr_valid[p] = v;
    bus_b.in_proto_hdr_length[p*16 +: 16] = len;
    bus_b.in_proto_hdr_phv[p*32 +: 32] = phv;
    bus_b.in_proto_hdr_data[p*64 +: 64] = d[63:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [407:0] phv_s;
    m_np[0] = 2; m_stamp[0] = 1'b1; m_cw[0] = 32;
    m_np[1] = 3; m_stamp[1] = 1'b0; m_cw[1] = 8;
    model_reset(0);
    model_reset(1);
    rst_a = 1'b0;
    rst_b = 1'b0;
    bus_a.in_proto_hdr_valid  = '0;
    bus_a.in_proto_hdr_length = '0;
    bus_a.in_proto_hdr_phv    = '0;
    bus_a.in_proto_hdr_data   = '0;
    bus_a.out_proto_hdr_ready = 1'b1;
    bus_b.in_proto_hdr_valid  = '0;
    bus_b.in_proto_hdr_length = '0;
    bus_b.in_proto_hdr_phv    = '0;
    bus_b.in_proto_hdr_data   = '0;
    bus_b.out_proto_hdr_ready = 1'b1;
    repeat (2) tick();
    chk("reset_valid", 64'(bus_a.out_proto_hdr_valid), 64'd0);
    chk("reset_cnt", 64'(bus_a.accept_cnt), 64'd0);
    rst_a = 1'b1;
    rst_b = 1'b1;

    // single port streaming
    for (int i = 1; i <= 4; i++) begin
      a_set(0, 1'b1, 16'(i * 10), mk_phv(16'(i * 10)));
      tick();
      chk("stream_len", 64'(bus_a.out_proto_hdr_length), 64'(i * 10));
      chk("stream_port", 64'(bus_a.out_grant_port), 64'd0);
    end
    chk("stream_cnt0", 64'(bus_a.accept_cnt[31:0]), 64'd4);
    a_set(0, 1'b0, 16'd0, '0);
    tick();
    chk("stream_pop", 64'(bus_a.out_proto_hdr_valid), 64'd0);

    // round-robin contention from reset
    rst_a = 1'b0;
    a_set(0, 1'b1, 16'd100, mk_phv(16'd100));
    a_set(1, 1'b1, 16'd101, mk_phv(16'd101));
    tick();
    rst_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr_port", 64'(bus_a.out_grant_port), 64'(i % 2));
    end
    chk("rr_cnt0", 64'(bus_a.accept_cnt[31:0]), 64'd3);
    chk("rr_cnt1", 64'(bus_a.accept_cnt[63:32]), 64'd3);

    // backpressure with port 1 beat held
    bus_a.out_proto_hdr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_ready", 64'(bus_a.in_proto_hdr_ready), 64'd0);
      chk("bp_port", 64'(bus_a.out_grant_port), 64'd1);
      chk("bp_len", 64'(bus_a.out_proto_hdr_length), 64'd101);
    end
    bus_a.out_proto_hdr_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(bus_a.in_proto_hdr_ready), 64'b01);
    tick();
    chk("bp_next_port", 64'(bus_a.out_grant_port), 64'd0);
    chk("bp_next_len", 64'(bus_a.out_proto_hdr_length), 64'd100);
    a_set(0, 1'b0, 16'd0, '0);
    a_set(1, 1'b0, 16'd0, '0);
    tick();

    // stamping on instance a
    phv_s = '0;
    phv_s[23:16] = 8'hFF;
    phv_s[15:8]  = 8'h80;
    a_set(1, 1'b1, 16'd7, phv_s);
    tick();
    a_set(1, 1'b0, 16'd0, '0);
    chk("stamp_byte2", 64'(bus_a.out_proto_hdr_phv[23:16]), 64'h01);
    chk("stamp_byte1", 64'(bus_a.out_proto_hdr_phv[15:8]), 64'h80);
    tick();

    // reset mid-stream
    a_set(0, 1'b1, 16'd55, mk_phv(16'd55));
    tick();
    chk("mid_pre_valid", 64'(bus_a.out_proto_hdr_valid), 64'd1);
    #2;
    rst_a = 1'b0;
    #1;
    chk("mid_valid", 64'(bus_a.out_proto_hdr_valid), 64'd0);
    chk("mid_len", 64'(bus_a.out_proto_hdr_length), 64'd0);
    chk("mid_port", 64'(bus_a.out_grant_port), 64'd0);
    chk("mid_cnt", 64'(bus_a.accept_cnt), 64'd0);
    chk("mid_ready", 64'(bus_a.in_proto_hdr_ready), 64'd0);
    chk_w("mid_phv", 2048'(bus_a.out_proto_hdr_phv), '0);
    chk_w("mid_data", bus_a.out_proto_hdr_data, '0);
    a_set(1, 1'b1, 16'd66, mk_phv(16'd66));
    tick();
    chk("mid_hold_valid", 64'(bus_a.out_proto_hdr_valid), 64'd0);
    rst_a = 1'b1;
    tick();
    chk("mid_first_port", 64'(bus_a.out_grant_port), 64'd0);
    chk("mid_first_len", 64'(bus_a.out_proto_hdr_length), 64'd55);
    a_set(0, 1'b0, 16'd0, '0);
    a_set(1, 1'b0, 16'd0, '0);
    tick();

    // dropped request on instance b
    b_set(0, 1'b1, 16'd1, 32'h11);
    tick();
    chk("drop_first_port", 64'(bus_b.out_grant_port), 64'd0);
    b_set(0, 1'b0, 16'd0, '0);
    bus_b.out_proto_hdr_ready = 1'b0;
    b_set(1, 1'b1, 16'd2, 32'h22);
    tick();
    chk("drop_stall_ready", 64'(bus_b.in_proto_hdr_ready), 64'd0);
    chk("drop_stall_len", 64'(bus_b.out_proto_hdr_length), 64'd1);
    b_set(1, 1'b0, 16'd0, '0);
    b_set(2, 1'b1, 16'd3, 32'h33);
    bus_b.out_proto_hdr_ready = 1'b1;
    #1;
    chk("drop_ready", 64'(bus_b.in_proto_hdr_ready), 64'b100);
    tick();
    chk("drop_port", 64'(bus_b.out_grant_port), 64'd2);
    chk("drop_len", 64'(bus_b.out_proto_hdr_length), 64'd3);
    chk("drop_cnt1", 64'(bus_b.accept_cnt[15:8]), 64'd0);
    chk("drop_cnt2", 64'(bus_b.accept_cnt[23:16]), 64'd1);
    b_set(2, 1'b0, 16'd0, '0);

    // no stamping on instance b
    b_set(1, 1'b1, 16'd9, 32'h00FF_8000);
    tick();
    b_set(1, 1'b0, 16'd0, '0);
    chk("nostamp_byte2", 64'(bus_b.out_proto_hdr_phv[23:16]), 64'hFF);
    chk("nostamp_byte1", 64'(bus_b.out_proto_hdr_phv[15:8]), 64'h80);
    chk("nostamp_port", 64'(bus_b.out_grant_port), 64'd1);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
